// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ
// Universal shift register with single-step operation and a counted burst
// engine. A single step applies the live mode once when en is high. A burst
// is requested with a one-cycle start pulse. It captures mode and count, then
// applies that captured mode once per cycle until the count is used up.
//
// Parameters
//   WIDTH  register width in bits (2 or more)
//   CNT_W  burst-count width in bits
//
// Ports
//   clk    clock, all state changes on the rising edge
//   rst    synchronous active-high reset
//   en     single-step enable (honoured only when idle and start is low)
//   mode   operation select:
//            000 hold, 001 shl, 010 shr, 011 load, 100 rol, 101 ror,
//            110 asr, 111 clear
//   in     serial data in
//   pin    parallel load data
//   start  burst request pulse
//   count  burst length, sampled with start
//   q      register contents
//   out_l  q msb
//   out_r  q lsb
//   busy   burst in progress
//   done   one-cycle pulse when a burst (or a rejected start) completes
// -----------------------------------------------------------------------------
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             in,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             out_l,
    output logic             out_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       modeLat_q, modeLat_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             done_q, done_d;

    // One application of an operation to the current register value.
    function automatic logic [WIDTH-1:0] applyOp(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic             serIn,
        input logic [WIDTH-1:0] par
    );
        logic [WIDTH-1:0] res;
        case (op)
            3'b001:  res = {cur[WIDTH-2:0], serIn};
            3'b010:  res = {serIn, cur[WIDTH-1:1]};
            3'b011:  res = par;
            3'b100:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'b101:  res = {cur[0], cur[WIDTH-1:1]};
            3'b110:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            3'b111:  res = '0;
            default: res = cur;
        endcase
        return res;
    endfunction

    // Only the shift and rotate modes make sense to repeat. Hold, load and
    // clear are refused as bursts.
    function automatic logic burstable(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b010) || (op == 3'b100) ||
               (op == 3'b101) || (op == 3'b110);
    endfunction

    // State register. Reset wins over everything, including an active burst,
    // and it also kills any pending done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            modeLat_q <= '0;
            remain_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            modeLat_q <= modeLat_d;
            remain_q  <= remain_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic. While idle, start takes precedence over en and leaves
    // q untouched in its own cycle. While running, all request inputs are
    // ignored. The edge that consumes the last count returns to IDLE and
    // raises done for the following cycle.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        modeLat_d = modeLat_q;
        remain_d  = remain_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    modeLat_d = mode;
                    remain_d  = count;
                    if ((count != '0) && burstable(mode)) begin
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (en) begin
                    data_d = applyOp(mode, data_q, in, pin);
                end
            end
            RUN: begin
                data_d = applyOp(modeLat_q, data_q, in, pin);
                if (remain_q != '0) begin
                    remain_d = remain_q - CNT_W'(1);
                end
                if (remain_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign q     = data_q;
    assign out_l = data_q[WIDTH-1];
    assign out_r = data_q[0];
    assign busy  = (state_q == RUN);
    assign done  = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_univ
// Scoreboard bench for shift_reg_univ (WIDTH=8, CNT_W=4). Each stimulus cycle
// steps a behavioural model and pushes the expected post-edge outputs to a
// queue. After the edge, the entry is popped and compared with the DUT. Fixed
// vectors from the worked examples are checked against literal constants too.
// -----------------------------------------------------------------------------
module tb_shift_reg_univ;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic       in;
    logic [7:0] pin;
    logic       start;
    logic [3:0] count;
    logic [7:0] q;
    logic       out_l;
    logic       out_r;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t expQ[$];

    // Behavioural model state
    logic [7:0] mQ;
    logic       mRun;
    logic [3:0] mRem;
    logic [2:0] mMode;
    logic       mDone;

    shift_reg_univ #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .in    (in),
        .pin   (pin),
        .start (start),
        .count (count),
        .q     (q),
        .out_l (out_l),
        .out_r (out_r),
        .busy  (busy),
        .done  (done)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and log any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // One register operation, written straight from the mode table
    function automatic logic [7:0] modelOp(input logic [2:0] m,
                                           input logic [7:0] cur,
                                           input logic si,
                                           input logic [7:0] p);
        case (m)
            3'd1:    return {cur[6:0], si};
            3'd2:    return {si, cur[7:1]};
            3'd3:    return p;
            3'd4:    return {cur[6:0], cur[7]};
            3'd5:    return {cur[0], cur[7:1]};
            3'd6:    return {cur[7], cur[7:1]};
            3'd7:    return 8'h00;
            default: return cur;
        endcase
    endfunction

    // Advance the model across one rising edge using the current inputs
    task automatic modelEdge();
        if (rst) begin
            mQ = 8'h00; mRun = 1'b0; mRem = 4'd0; mDone = 1'b0;
        end else if (mRun) begin
            mQ    = modelOp(mMode, mQ, in, pin);
            mRem  = mRem - 4'd1;
            mDone = (mRem == 4'd0);
            mRun  = (mRem != 4'd0);
        end else begin
            mDone = 1'b0;
            if (start) begin
                mMode = mode;
                mRem  = count;
                if (count != 4'd0 && mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})
                    mRun = 1'b1;
                else
                    mDone = 1'b1;
            end else if (en) begin
                mQ = modelOp(mode, mQ, in, pin);
            end
        end
    endtask

    // Drive one cycle of inputs, push the prediction, clock, then pop/compare
    task automatic applyStimulus(input logic r, input logic e,
                                 input logic [2:0] m, input logic s,
                                 input logic [3:0] c, input logic [7:0] p,
                                 input logic si);
        exp_t e1;
        rst = r; en = e; mode = m; start = s; count = c; pin = p; in = si;
        modelEdge();
        expQ.push_back('{q: mQ, busy: mRun, done: mDone});
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput("sbEmpty", 32'd0, 32'd1);
        end else begin
            e1 = expQ.pop_front();
            checkOutput("q",     {24'd0, q}, {24'd0, e1.q});
            checkOutput("busy",  {31'd0, busy}, {31'd0, e1.busy});
            checkOutput("done",  {31'd0, done}, {31'd0, e1.done});
            checkOutput("out_l", {31'd0, out_l}, {31'd0, e1.q[7]});
            checkOutput("out_r", {31'd0, out_r}, {31'd0, e1.q[0]});
            checkOutput("excl",  {31'd0, busy & done}, 32'd0);
        end
    endtask

    // Idle cycle: nothing requested, serial input random
    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 1'($urandom));
    endtask

    initial begin
        mQ = 8'h00; mRun = 1'b0; mRem = 4'd0; mMode = 3'd0; mDone = 1'b0;
        rst = 1'b1; en = 1'b0; mode = 3'd0; in = 1'b0; pin = 8'h00;
        start = 1'b0; count = 4'd0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'd3, 1'b1, 4'd5, 8'hFF, 1'b1);
        checkOutput("rstQ",    {24'd0, q}, 32'h00);
        checkOutput("rstOutL", {31'd0, out_l}, 32'd0);
        checkOutput("rstOutR", {31'd0, out_r}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);

        // Single-step: load 81, shl in=0 -> 02, ror -> 01
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 4'd0, 8'h81, 1'b0);
        checkOutput("ldQ", {24'd0, q}, 32'h81);
        applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 4'd0, 8'h00, 1'b0);
        checkOutput("shlQ", {24'd0, q}, 32'h02);
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b0, 4'd0, 8'h00, 1'b0);
        checkOutput("rorQ", {24'd0, q}, 32'h01);
        applyStimulus(1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 8'hFF, 1'b1);
        checkOutput("holdQ", {24'd0, q}, 32'h01);

        // Rotate-left burst of 3 from 01 -> 08
        applyStimulus(1'b0, 1'b1, 3'd4, 1'b1, 4'd3, 8'h00, 1'($urandom));
        checkOutput("rolStartQ", {24'd0, q}, 32'h01);
        checkOutput("rolBusy0", {31'd0, busy}, 32'd1);
        idleCycle();
        idleCycle();
        checkOutput("rolBusy2", {31'd0, busy}, 32'd1);
        idleCycle();
        checkOutput("rolQ",    {24'd0, q}, 32'h08);
        checkOutput("rolDone", {31'd0, done}, 32'd1);
        checkOutput("rolIdle", {31'd0, busy}, 32'd0);
        idleCycle();
        checkOutput("rolDoneOff", {31'd0, done}, 32'd0);

        // Arithmetic-right burst of 7 from 80 -> FF
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 4'd0, 8'h80, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd6, 1'b1, 4'd7, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) idleCycle();
        checkOutput("asrQ",    {24'd0, q}, 32'hFF);
        checkOutput("asrDone", {31'd0, done}, 32'd1);

        // Degenerate starts: count 0, then non-burstable mode
        applyStimulus(1'b0, 1'b1, 3'd1, 1'b1, 4'd0, 8'h00, 1'b0);
        checkOutput("deg0Busy", {31'd0, busy}, 32'd0);
        checkOutput("deg0Done", {31'd0, done}, 32'd1);
        checkOutput("deg0Q",    {24'd0, q}, 32'hFF);
        idleCycle();
        checkOutput("deg0DoneOff", {31'd0, done}, 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd3, 1'b1, 4'd5, 8'h12, 1'b0);
        checkOutput("degLdDone", {31'd0, done}, 32'd1);
        checkOutput("degLdQ",    {24'd0, q}, 32'hFF);
        idleCycle();

        // Ignore and back-to-back: clear, shr burst of 2 with in=1 -> C0
        applyStimulus(1'b0, 1'b1, 3'd7, 1'b0, 4'd0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd2, 1'b1, 4'd2, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'd7, 1'b1, 4'd15, 8'h55, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b1, 4'd9, 8'hAA, 1'b1);
        checkOutput("ignQ",    {24'd0, q}, 32'hC0);
        checkOutput("ignDone", {31'd0, done}, 32'd1);
        applyStimulus(1'b0, 1'b0, 3'd1, 1'b1, 4'd1, 8'h00, 1'b0);
        checkOutput("b2bBusy", {31'd0, busy}, 32'd1);
        checkOutput("b2bDone", {31'd0, done}, 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0);
        checkOutput("b2bQ",    {24'd0, q}, 32'h80);
        checkOutput("b2bDn",   {31'd0, done}, 32'd1);

        // Reset mid-burst from A5 aborts without done
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 4'd0, 8'hA5, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd4, 1'b1, 4'd10, 8'h00, 1'b0);
        idleCycle();
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0);
        checkOutput("abortQ",    {24'd0, q}, 32'h00);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            idleCycle();
            checkOutput("abortNoDone", {31'd0, done}, 32'd0);
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 40) == 0),
                          1'($urandom), 3'($urandom),
                          ($urandom_range(0, 5) == 0), 4'($urandom),
                          8'($urandom), 1'($urandom));
        end

        checkOutput("sbDrained", expQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning register width in bits; legal values are 2 and above.
REQ-002 SHALL have parameter CNT_W, default 4, meaning burst-count width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: single-step enable; executes mode for one cycle.
REQ-006 SHALL have port mode, input, 3 bits: operation select per REQ-015.
REQ-007 SHALL have port in, input, 1 bit: serial data in, sampled on every shift edge.
REQ-008 SHALL have port pin, input, WIDTH bits: parallel load data.
REQ-009 SHALL have port start, input, 1 bit: burst request, one-cycle pulse.
REQ-010 SHALL have port count, input, CNT_W bits: number of burst steps, sampled with start.
REQ-011 SHALL have port q, output, WIDTH bits: register contents.
REQ-012 SHALL have port out_l, output, 1 bit: combinational q[WIDTH-1].
REQ-013 SHALL have port out_r, output, 1 bit: combinational q[0].
REQ-014 SHALL have ports busy and done, output, 1 bit each: burst in progress, and burst-complete pulse.

Function
REQ-015 Mode encoding SHALL be:
- 000 hold
- 001 shift left: q <= {q[WIDTH-2:0], in}
- 010 shift right: q <= {in, q[WIDTH-1:1]}
- 011 parallel load: q <= pin
- 100 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}
- 101 rotate right: q <= {q[0], q[WIDTH-1:1]}
- 110 arithmetic right: q <= {q[WIDTH-1], q[WIDTH-1:1]}; in is ignored
- 111 clear: q <= 0
REQ-016 In IDLE, en=1 with start=0 SHALL apply mode once at that edge; en=0 with start=0 SHALL hold q.
REQ-017 FSM SHALL have exactly two states, IDLE and RUN.
REQ-018 IDLE with start=1 SHALL latch mode and count into internal registers, and SHALL take precedence over en.
REQ-019 In that same cycle, q SHALL be unchanged.
REQ-020 Start SHALL go to RUN only when the latched count is nonzero and the latched mode is in {001,010,100,101,110}.
REQ-021 Otherwise, start SHALL stay in IDLE and assert done for exactly the next cycle with q unchanged.
REQ-022 In RUN, each edge SHALL apply the latched mode once, using the live in value, and decrement the remaining count.
REQ-023 The edge that performs the last step SHALL return the FSM to IDLE.
REQ-024 A burst of N steps SHALL hold busy=1 for exactly N cycles.
REQ-025 done SHALL be 1 for exactly one cycle, coincident with the first IDLE cycle after RUN.
REQ-026 In RUN, en, start, mode, count and pin SHALL be ignored.
REQ-027 Changes to mode or count during RUN SHALL NOT affect the active burst.
REQ-028 busy SHALL be 1 in RUN and 0 in IDLE; busy and done SHALL never both be 1.
REQ-029 A start in the cycle done=1 SHALL be accepted as a new burst per REQ-018.
REQ-030 The maximum burst length SHALL be 2^CNT_W-1.
REQ-031 count values of WIDTH or more SHALL be legal, and behave as repeated single steps.
REQ-032 No arithmetic SHALL overflow: the remaining-count register is CNT_W bits and only decrements while nonzero.

Reset
REQ-033 With rst=1 at an edge: q=0, FSM=IDLE, busy=0, done=0, remaining count=0.
REQ-034 rst SHALL take priority over en, start and RUN activity.
REQ-035 Reset during RUN SHALL abort the burst with no done pulse.
REQ-036 After reset, out_l=0 and out_r=0.

Verification
REQ-037 Reset: q=8'hA5 mid-burst, then assert rst -> next cycle q=8'h00, busy=0, done stays 0 thereafter.
REQ-038 Single-step: load pin=8'h81 (mode 011, en=1); then mode 001, in=0, one en -> q=8'h02; then mode 101, one en -> q=8'h01.
REQ-039 Burst: q=8'h01, start with mode 100, count=3, in=X -> busy=1 for 3 cycles, q=8'h08, done pulse 1 cycle.
REQ-040 Arithmetic burst: q=8'h80, start with mode 110, count=7 -> q=8'hFF, done after 7 busy cycles.
REQ-041 Degenerate start: count=0 or mode=011 -> busy never 1, q unchanged, done=1 exactly one cycle later.
REQ-042 Ignore and back-to-back: during a burst of count=2 mode 010 in=1 from q=0, pulse en/start/change mode -> q=8'hC0, exactly one done; a start in the done cycle launches the next burst.
